// File: rtl/ps_seq_core.sv
// Program sequencer core: fetch/decode/execute address pipeline, execute-stage
// jump/call/return with two-slot squash, RUN/IDLE state machine, and a PC stack
// with live empty/full and sticky overflow/underflow flags.
module ps_seq_core #(
  parameter int unsigned AW        = 16,
  parameter int unsigned STK_DEPTH = 4,
  localparam int unsigned PW       = $clog2(STK_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          seq_jmp_en,
  input  logic          seq_call_en,
  input  logic          seq_rts_en,
  input  logic [AW-1:0] seq_tgt,
  input  logic          seq_idle,
  input  logic          seq_wake,
  input  logic          seq_push,
  input  logic          seq_pop,
  input  logic          seq_wr_top,
  input  logic [AW-1:0] seq_wdata,
  input  logic          seq_stky_clr,
  output logic [AW-1:0] pm_add,
  output logic          pm_cslt,
  output logic [AW-1:0] ps_faddr,
  output logic [AW-1:0] ps_daddr,
  output logic [AW-1:0] ps_pc,
  output logic          ps_dvalid,
  output logic          ps_pvalid,
  output logic [AW-1:0] stk_top,
  output logic [PW-1:0] stk_ptr,
  output logic [3:0]    stcky
);

  localparam int unsigned IW = $clog2(STK_DEPTH);

  typedef enum logic [0:0] {StRun, StIdle} state_e;

  state_e        st_q, st_d;
  logic [AW-1:0] faddr_q, faddr_d;
  logic [AW-1:0] daddr_q, daddr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          dvalid_q, dvalid_d;
  logic          pvalid_q, pvalid_d;

  logic [AW-1:0] stk_q [STK_DEPTH];
  logic [AW-1:0] stk_d [STK_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          ovf_set, unf_set;

  logic          stk_empty, stk_full;
  logic [PW-1:0] ptr_m1;
  logic [IW-1:0] top_idx, push_idx;
  logic [AW-1:0] top_val;

  logic          honour;
  logic          rts_go, call_go, jmp_go, idle_go, redirect;
  logic [AW-1:0] tgt;

  assign stk_empty = (ptr_q == '0);
  assign stk_full  = (ptr_q == PW'(STK_DEPTH));
  assign ptr_m1    = ptr_q - PW'(1);
  assign top_idx   = ptr_m1[IW-1:0];
  assign push_idx  = ptr_q[IW-1:0];
  assign top_val   = stk_empty ? '0 : stk_q[top_idx];

  // Control requests only count for a valid execute slot while running.
  assign honour   = (st_q == StRun) && pvalid_q;
  assign rts_go   = honour && seq_rts_en;
  assign call_go  = honour && seq_call_en && !seq_rts_en;
  assign jmp_go   = honour && seq_jmp_en && !seq_rts_en && !seq_call_en;
  assign idle_go  = honour && seq_idle && !seq_rts_en && !seq_call_en && !seq_jmp_en;
  assign redirect = rts_go || call_go || jmp_go;
  // An rts on an empty stack returns to address 0 (top_val is 0 then).
  assign tgt      = rts_go ? top_val : seq_tgt;

  // Next-state logic for the RUN/IDLE machine and the address pipeline.
  always_comb begin
    st_d     = st_q;
    faddr_d  = faddr_q;
    daddr_d  = daddr_q;
    pc_d     = pc_q;
    dvalid_d = dvalid_q;
    pvalid_d = pvalid_q;
    unique case (st_q)
      StRun: begin
        if (redirect) begin
          // Squash both in-flight slots; the target is fetched next.
          faddr_d  = tgt;
          daddr_d  = faddr_q;
          pc_d     = daddr_q;
          dvalid_d = 1'b0;
          pvalid_d = 1'b0;
        end else if (idle_go) begin
          // Freeze with the instruction after IDLE queued for wake-up.
          faddr_d  = pc_q + AW'(1);
          dvalid_d = 1'b0;
          pvalid_d = 1'b0;
          st_d     = StIdle;
        end else begin
          faddr_d  = faddr_q + AW'(1);
          daddr_d  = faddr_q;
          pc_d     = daddr_q;
          dvalid_d = 1'b1;
          pvalid_d = dvalid_q;
        end
      end
      StIdle: begin
        if (seq_wake) begin
          st_d = StRun;
        end
      end
      default: st_d = StRun;
    endcase
  end

  // Next-state logic for the PC stack; call/rts take precedence over explicit ops.
  always_comb begin
    stk_d   = stk_q;
    ptr_d   = ptr_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (call_go) begin
      if (stk_full) begin
        ovf_set = 1'b1;
      end else begin
        stk_d[push_idx] = pc_q + AW'(1);
        ptr_d           = ptr_q + PW'(1);
      end
    end else if (rts_go) begin
      if (stk_empty) begin
        unf_set = 1'b1;
      end else begin
        ptr_d = ptr_m1;
      end
    end else if (seq_push && seq_pop) begin
      if (!stk_empty) begin
        stk_d[top_idx] = seq_wdata;
      end
    end else if (seq_push) begin
      if (stk_full) begin
        ovf_set = 1'b1;
      end else begin
        stk_d[push_idx] = seq_wdata;
        ptr_d           = ptr_q + PW'(1);
      end
    end else if (seq_pop) begin
      if (stk_empty) begin
        unf_set = 1'b1;
      end else begin
        ptr_d = ptr_m1;
      end
    end else if (seq_wr_top && !stk_empty) begin
      stk_d[top_idx] = seq_wdata;
    end
    // A set in the same cycle as a clear wins.
    ovf_d = (ovf_q && !seq_stky_clr) || ovf_set;
    unf_d = (unf_q && !seq_stky_clr) || unf_set;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= StRun;
      faddr_q  <= '0;
      daddr_q  <= '0;
      pc_q     <= '0;
      dvalid_q <= 1'b0;
      pvalid_q <= 1'b0;
      stk_q    <= '{default: '0};
      ptr_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      faddr_q  <= faddr_d;
      daddr_q  <= daddr_d;
      pc_q     <= pc_d;
      dvalid_q <= dvalid_d;
      pvalid_q <= pvalid_d;
      stk_q    <= stk_d;
      ptr_q    <= ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign pm_add    = faddr_q;
  assign pm_cslt   = (st_q == StRun);
  assign ps_faddr  = faddr_q;
  assign ps_daddr  = daddr_q;
  assign ps_pc     = pc_q;
  assign ps_dvalid = dvalid_q;
  assign ps_pvalid = pvalid_q;
  assign stk_top   = top_val;
  assign stk_ptr   = ptr_q;
  assign stcky     = {unf_q, ovf_q, stk_full, stk_empty};

endmodule
